// File: rtl/smem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smem_pkg
// Description : Shared defaults and index-width helper for the banked memory.
// Revision    : 1.0 - initial release
// ============================================================================
package smem_pkg;

    localparam int C_ADDR_BITS = 8;
    localparam int C_DATA_BITS = 8;
    localparam int C_SIZE      = 256;
    localparam int C_NUM_PORTS = 4;
    localparam int C_NUM_BANKS = 4;

    // Width needed to index n items; never less than one bit.
    function automatic int idx_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/banked_shared_memory_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter, one-hot grant, pointer follows the winner.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import smem_pkg::*;
#(
    parameter int NUM_PORTS = C_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int PTR_BITS = idx_bits(NUM_PORTS);

    logic [PTR_BITS-1:0] r_ptr;
    logic [PTR_BITS-1:0] w_ptr_next;
    logic [PTR_BITS-1:0] w_cand_idx;
    logic                w_found;
    int                  w_cand;

    // Scan from the pointer, wrapping once; the first requester wins.
    always_comb begin
        grant      = '0;
        w_ptr_next = r_ptr;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= NUM_PORTS) begin
                w_cand = w_cand - NUM_PORTS;
            end
            w_cand_idx = PTR_BITS'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                w_found           = 1'b1;
                grant[w_cand_idx] = 1'b1;
                w_ptr_next        = (w_cand == NUM_PORTS - 1) ? '0 : PTR_BITS'(w_cand + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/banked_shared_memory.sv
`default_nettype none
// ============================================================================
// Module      : banked_shared_memory
// Description : Multi-port shared memory, low address bits select the bank,
//               one round-robin arbiter per bank. Define SMEM_BROADCAST_EN to
//               let same-address reads share the winning read's bank slot.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_shared_memory
    import smem_pkg::*;
#(
    parameter int ADDR_BITS = C_ADDR_BITS,
    parameter int DATA_BITS = C_DATA_BITS,
    parameter int SIZE      = C_SIZE,
    parameter int NUM_PORTS = C_NUM_PORTS,
    parameter int NUM_BANKS = C_NUM_BANKS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           req_we,
    input  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_BITS-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]           resp_valid,
    output logic [NUM_PORTS*DATA_BITS-1:0] resp_rdata
);

    localparam int BANK_BITS = idx_bits(NUM_BANKS);
    localparam int MEM_BITS  = idx_bits(SIZE);

    // Word index equals the address for in-range requests, so bank b owns
    // every word whose low BANK_BITS equal b.
    logic [SIZE-1:0][DATA_BITS-1:0]      r_mem;
    logic [NUM_PORTS-1:0]                r_resp_valid;
    logic [NUM_PORTS-1:0][DATA_BITS-1:0] r_resp_rdata;

    logic [ADDR_BITS-1:0] w_addr       [NUM_PORTS];
    logic [MEM_BITS-1:0]  w_idx        [NUM_PORTS];
    logic [BANK_BITS-1:0] w_bank       [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_in_range;
    logic [NUM_PORTS-1:0] w_bank_req   [NUM_BANKS];
    logic [NUM_PORTS-1:0] w_arb_gnt    [NUM_BANKS];
    logic [NUM_PORTS-1:0] w_gnt;
    logic [NUM_BANKS-1:0] w_bank_we;
    logic [MEM_BITS-1:0]  w_bank_idx   [NUM_BANKS];
    logic [DATA_BITS-1:0] w_bank_wdata [NUM_BANKS];

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_addr[p]     = req_addr[p*ADDR_BITS +: ADDR_BITS];
            w_in_range[p] = 32'(w_addr[p]) < 32'(SIZE);
            w_idx[p]      = MEM_BITS'(32'(w_addr[p]));
            w_bank[p]     = BANK_BITS'(w_addr[p]);
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_bank_req[b][p] = req_valid[p] && (w_bank[p] == BANK_BITS'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank_arb
        rr_arbiter #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (w_bank_req[b]),
            .grant (w_arb_gnt[b])
        );
    end

    // Route each bank winner to the write path and collect the port grants.
    always_comb begin
        w_gnt     = '0;
        w_bank_we = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_idx[b]   = '0;
            w_bank_wdata[b] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_arb_gnt[b][p]) begin
                    w_gnt[p]        = 1'b1;
                    w_bank_we[b]    = req_we[p] && w_in_range[p];
                    w_bank_idx[b]   = w_idx[p];
                    w_bank_wdata[b] = req_wdata[p*DATA_BITS +: DATA_BITS];
`ifdef SMEM_BROADCAST_EN
                    if (!req_we[p] && w_in_range[p]) begin
                        for (int q = 0; q < NUM_PORTS; q++) begin
                            if (w_bank_req[b][q] && !req_we[q] && (w_addr[q] == w_addr[p])) begin
                                w_gnt[q] = 1'b1;
                            end
                        end
                    end
`endif
                end
            end
        end
        req_ready = reset ? '0 : w_gnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_bank_we[b]) begin
                    r_mem[w_bank_idx[b]] <= w_bank_wdata[b];
                end
            end
        end
    end

    // Read data is sampled from the pre-edge memory contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_gnt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_resp_rdata[p] <= (w_gnt[p] && !req_we[p] && w_in_range[p]) ? r_mem[w_idx[p]] : '0;
            end
        end
    end

    // Gating with reset suppresses the response of a request in flight at reset.
    always_comb begin
        resp_valid = reset ? '0 : r_resp_valid;
        resp_rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            resp_rdata[p*DATA_BITS +: DATA_BITS] = resp_valid[p] ? r_resp_rdata[p] : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_shared_memory.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_banked_shared_memory
// Description : Directed scenarios plus random traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_shared_memory;

    localparam int NP = 4;
    localparam int NB = 4;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int SZ = 256;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    req_we = '0;
    logic [NP*AW-1:0] req_addr = '0;
    logic [NP*DW-1:0] req_wdata = '0;
    logic [NP-1:0]    resp_valid;
    logic [NP*DW-1:0] resp_rdata;

    banked_shared_memory #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .SIZE      (SZ),
        .NUM_PORTS (NP),
        .NUM_BANKS (NB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Requester state and reference model
    bit pend_v    [NP];
    bit pend_we   [NP];
    int pend_addr [NP];
    int pend_wdata[NP];
    int ptr       [NB];
    int mem       [SZ];
    bit exp_v     [NP];
    int exp_d     [NP];
    int gnt_cyc   [NP];
    int last_rd   [NP];
    int last_ready;
    int last_valid;
    int cyc = 0;
    int n;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int p, input bit we, input int addr, input int wdata);
        pend_v[p]     = 1'b1;
        pend_we[p]    = we;
        pend_addr[p]  = addr;
        pend_wdata[p] = wdata;
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int p = 0; p < NP; p++) r |= pend_v[p];
        return r;
    endfunction

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input bit rst);
        bit gnt[NP];
        int w;
        int q;
        reset = rst;
        for (int p = 0; p < NP; p++) begin
            req_valid[p]          = pend_v[p];
            req_we[p]             = pend_we[p];
            req_addr[p*AW +: AW]  = AW'(pend_addr[p]);
            req_wdata[p*DW +: DW] = DW'(pend_wdata[p]);
        end
        #1;
        last_ready = int'(req_ready);
        last_valid = int'(resp_valid);
        for (int p = 0; p < NP; p++) begin
            check_val($sformatf("resp_valid[%0d] cyc%0d", p, cyc), int'(resp_valid[p]), rst ? 0 : int'(exp_v[p]));
            check_val($sformatf("resp_rdata[%0d] cyc%0d", p, cyc), int'(resp_rdata[p*DW +: DW]), rst ? 0 : exp_d[p]);
            if (resp_valid[p]) last_rd[p] = int'(resp_rdata[p*DW +: DW]);
            gnt[p] = 1'b0;
        end
        if (!rst) begin
            for (int b = 0; b < NB; b++) begin
                w = -1;
                for (int k = 0; k < NP; k++) begin
                    q = (ptr[b] + k) % NP;
                    if (w < 0 && pend_v[q] && (pend_addr[q] % NB) == b) w = q;
                end
                if (w >= 0) begin
                    gnt[w] = 1'b1;
                    ptr[b] = (w + 1) % NP;
`ifdef SMEM_BROADCAST_EN
                    if (!pend_we[w] && pend_addr[w] < SZ) begin
                        for (int r = 0; r < NP; r++) begin
                            if (pend_v[r] && !pend_we[r] && pend_addr[r] == pend_addr[w]) gnt[r] = 1'b1;
                        end
                    end
`endif
                end
            end
        end
        for (int p = 0; p < NP; p++) begin
            check_val($sformatf("req_ready[%0d] cyc%0d", p, cyc), int'(req_ready[p]), int'(gnt[p]));
        end
        for (int p = 0; p < NP; p++) begin
            exp_v[p] = gnt[p];
            exp_d[p] = (gnt[p] && !pend_we[p] && pend_addr[p] < SZ) ? mem[pend_addr[p]] : 0;
        end
        for (int p = 0; p < NP; p++) begin
            if (gnt[p] && pend_we[p] && pend_addr[p] < SZ) mem[pend_addr[p]] = pend_wdata[p] & 8'hFF;
            if (gnt[p]) begin
                gnt_cyc[p] = cyc;
                pend_v[p]  = 1'b0;
            end
        end
        if (rst) begin
            for (int b = 0; b < NB; b++) ptr[b] = 0;
            for (int i = 0; i < SZ; i++) mem[i] = 0;
            for (int p = 0; p < NP; p++) begin
                exp_v[p]  = 1'b0;
                exp_d[p]  = 0;
                pend_v[p] = 1'b0;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_idle(output int cycles);
        cycles = 0;
        while (any_pend() && cycles < 50) begin
            step(1'b0);
            cycles++;
        end
        check_val("drain", int'(any_pend()), 0);
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            pend_v[p] = 1'b0; exp_v[p] = 1'b0; exp_d[p] = 0; last_rd[p] = -1; gnt_cyc[p] = 0;
        end
        @(negedge clk);
        step(1'b1);
        step(1'b1);

        // Four distinct banks in one cycle, then read back
        for (int p = 0; p < NP; p++) issue(p, 1'b1, p, 'h11 * (p + 1));
        run_idle(n);
        check_val("wr4_cycles", n, 1);
        step(1'b0);
        check_val("wr4_resp_valid", last_valid, 'hF);
        for (int p = 0; p < NP; p++) issue(p, 1'b0, p, 0);
        run_idle(n);
        check_val("rd4_cycles", n, 1);
        step(1'b0);
        for (int p = 0; p < NP; p++) check_val($sformatf("rdback[%0d]", p), last_rd[p], 'h11 * (p + 1));

        // Four-way bank-0 conflict from a reset pointer
        step(1'b1);
        issue(0, 1'b0, 4, 0); issue(1, 1'b0, 8, 0); issue(2, 1'b0, 12, 0); issue(3, 1'b0, 0, 0);
        run_idle(n);
        check_val("conflict_cycles", n, 4);
        for (int p = 1; p < NP; p++) check_val($sformatf("conflict_order[%0d]", p), gnt_cyc[p] - gnt_cyc[p-1], 1);
        step(1'b0);
        issue(3, 1'b0, 0, 0); issue(0, 1'b0, 4, 0);
        step(1'b0);
        check_val("wrap_first", last_ready, 'h1);
        run_idle(n);
        step(1'b0);

        // Write/read race on address 6, then read-before-write
        issue(0, 1'b1, 6, 'h5A); issue(1, 1'b0, 6, 0);
        step(1'b0);
        check_val("raw_winner", last_ready, 'h1);
        run_idle(n);
        step(1'b0);
        check_val("raw_rdata", last_rd[1], 'h5A);
        issue(2, 1'b0, 6, 0); issue(3, 1'b1, 6, 'h77);
        step(1'b0);
        check_val("rbw_winner", last_ready, 'h4);
        step(1'b0);
        check_val("rbw_old", last_rd[2], 'h5A);
        step(1'b0);

        // Out-of-range handling
        issue(2, 1'b1, 255, 'hE7); run_idle(n);
        issue(2, 1'b1, 300, 'h99); run_idle(n);
        last_rd[2] = -1;
        issue(2, 1'b0, 300, 0); run_idle(n); step(1'b0);
        check_val("oor_read", last_rd[2], 0);
        issue(2, 1'b0, 255, 0); issue(0, 1'b0, 44, 0); run_idle(n); step(1'b0);
        check_val("rd255", last_rd[2], 'hE7);
        check_val("no_alias44", last_rd[0], 0);

        // Reset during a four-way conflict
        issue(1, 1'b1, 5, 'hC3); run_idle(n);
        issue(0, 1'b0, 4, 0); issue(1, 1'b0, 8, 0); issue(2, 1'b0, 12, 0); issue(3, 1'b0, 0, 0);
        step(1'b0);
        issue(0, 1'b0, 4, 0); issue(1, 1'b0, 8, 0); issue(2, 1'b0, 12, 0); issue(3, 1'b0, 0, 0);
        step(1'b1);
        step(1'b0);
        check_val("post_rst_valid", last_valid, 0);
        issue(0, 1'b0, 4, 0); issue(1, 1'b0, 8, 0); issue(2, 1'b0, 12, 0); issue(3, 1'b0, 0, 0);
        step(1'b0);
        check_val("post_rst_first", last_ready, 'h1);
        run_idle(n); step(1'b0);
        for (int p = 0; p < NP; p++) issue(p, 1'b0, p + 4, 0);
        run_idle(n); step(1'b0);
        for (int p = 0; p < NP; p++) check_val($sformatf("cleared[%0d]", p), last_rd[p], 0);

        // Four reads of one address
        issue(0, 1'b1, 9, 'h3C); run_idle(n); step(1'b0);
        for (int p = 0; p < NP; p++) issue(p, 1'b0, 9, 0);
        run_idle(n);
`ifdef SMEM_BROADCAST_EN
        check_val("same_addr_cycles", n, 1);
`else
        check_val("same_addr_cycles", n, 4);
`endif
        step(1'b0);
        for (int p = 0; p < NP; p++) check_val($sformatf("same_addr_data[%0d]", p), last_rd[p], 'h3C);

        // Random traffic, clustered on low addresses to force conflicts
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend_v[p] && $urandom_range(0, 1) == 1) begin
                    issue(p, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0) ? int'($urandom_range(240, 511)) : int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 255)));
                end
            end
            step($urandom_range(0, 99) == 0);
        end
        run_idle(n);
        step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
